// File: rtl/acc_arb_pkg.sv
// ---------------------------------------------------------------------------
// acc_arb_pkg
// Shared types and constants for the accumulating-buffer write arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BURST, PAUSE)
//   NREQ_DEF    : default requester count
//   IDW         : source-id width for the default requester count
//   VAL_*/IDX_* : field layout of a beat (value in [31:0], slot index above it)
//   STAT_W      : width of one per-requester beat counter
//   BCNT_W      : burst counter width (holds MAX_BURST up to 255)
// ---------------------------------------------------------------------------
package acc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    PAUSE = 2'd2
  } arb_state_e;

  localparam int NREQ_DEF = 4;
  localparam int IDW      = $clog2(NREQ_DEF);

  localparam int VAL_LSB  = 0;
  localparam int VAL_W    = 32;
  localparam int IDX_LSB  = 32;

  localparam int STAT_W   = 32;
  localparam int BCNT_W   = 8;

endpackage

// File: rtl/acc_buf_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request
// strictly after `last`, searching cyclically (last itself is tried last).
//   req  in  NREQ  request vector
//   last in  IDW   index granted most recently
//   any  out 1     at least one request is asserted
//   pick out IDW   chosen index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick
  import acc_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = acc_arb_pkg::IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  pick
);

  // (base + off) mod NREQ without a divider; off is at most NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    any  = |req;
    pick = '0;
    // Walk from the farthest candidate to the nearest; the nearest hit wins.
    for (int i = NREQ; i >= 1; i--) begin
      if (req[wrap_add(last, i)]) pick = wrap_add(last, i);
    end
  end

endmodule

// File: rtl/acc_buf_arbiter.sv
// ---------------------------------------------------------------------------
// acc_buf_arbiter
// Shares the single write port of the accumulating circular buffer between
// NREQ stream sources. Round-robin grants in bursts of up to MAX_BURST beats,
// one registered output slice, software pause handshake.
//
// Ports
//   clock, reset   single rising-edge clock, synchronous active-high reset
//   s_axis_tvalid  per-requester valid
//   s_axis_tdata   requester r at [r*DBITS +: DBITS]
//   s_axis_tready  per-requester ready (combinational, at most one bit set)
//   m_axis_tvalid  registered beat valid to the buffer write side
//   m_axis_tdata   registered beat
//   m_axis_tuser   registered source id of the beat
//   m_axis_tready  buffer accepts
//   pause_req      level request to stop granting
//   pause_ack      registered: paused and output slice empty
//   stat_beats     per-requester accepted-beat counters, 32 bits each
//
// Build option
//   ACC_ARB_STATS_EN : when defined, stat_beats counts transfers per requester
//                      (wrapping, cleared by reset); otherwise tied to 0.
// ---------------------------------------------------------------------------
module acc_buf_arbiter
  import acc_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DBITS     = 64,
  parameter int ABITS     = 7,
  parameter int MAX_BURST = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           s_axis_tvalid,
  input  logic [NREQ*DBITS-1:0]     s_axis_tdata,
  output logic [NREQ-1:0]           s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [DBITS-1:0]          m_axis_tdata,
  output logic [$clog2(NREQ)-1:0]   m_axis_tuser,
  input  logic                      m_axis_tready,
  input  logic                      pause_req,
  output logic                      pause_ack,
  output logic [NREQ*STAT_W-1:0]    stat_beats
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [BCNT_W-1:0] MAX_CNT = BCNT_W'(MAX_BURST);

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                m_valid_q, m_valid_d;
  logic [DBITS-1:0]    m_data_q, m_data_d;
  logic [ID_W-1:0]     m_user_q, m_user_d;
  logic                pause_ack_q, pause_ack_d;

  logic                pick_any;
  logic [ID_W-1:0]     pick_id;
  logic                slot_free;
  logic                grant_vld;
  logic                xfer;
  logic [BCNT_W-1:0]   burst_inc;
  logic [DBITS-1:0]    sel_beat;
  logic [DBITS-1:0]    load_beat;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (ID_W)
  ) u_pick (
    .req  (s_axis_tvalid),
    .last (last_grant_q),
    .any  (pick_any),
    .pick (pick_id)
  );

  // Slice can take a beat when empty or when its current beat leaves this cycle.
  assign slot_free = !m_valid_q || m_axis_tready;
  assign grant_vld = s_axis_tvalid[grant_q];
  assign xfer      = (state_q == BURST) && grant_vld && slot_free;
  assign burst_inc = burst_cnt_q + 1'b1;
  assign sel_beat  = s_axis_tdata[int'(grant_q)*DBITS +: DBITS];

  // Beats are forwarded untouched; value and slot fields are named so the
  // layout the buffer relies on is visible where the beat is captured.
  always_comb begin
    load_beat                   = sel_beat;
    load_beat[VAL_LSB +: VAL_W] = sel_beat[VAL_LSB +: VAL_W];
    load_beat[IDX_LSB +: ABITS] = sel_beat[IDX_LSB +: ABITS];
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == BURST && slot_free) s_axis_tready[grant_q] = 1'b1;
  end

  // Next-state, burst accounting and pause handshake.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    pause_ack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pause_req) begin
          state_d = PAUSE;
        end else if (pick_any) begin
          grant_d     = pick_id;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (xfer) burst_cnt_d = burst_inc;
        // A downstream stall alone keeps the burst open; pause is evaluated
        // after this cycle's transfer has been counted.
        if ((xfer && burst_inc == MAX_CNT) || !grant_vld || pause_req) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      PAUSE: begin
        if (!pause_req) state_d = IDLE;
        else            pause_ack_d = !m_valid_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slice: load on transfer, otherwise drain on acceptance.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_user_d  = m_user_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = load_beat;
      m_user_d  = grant_q;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
      burst_cnt_q  <= '0;
      m_valid_q    <= 1'b0;
      // NOTE: the data register is reset too because all outputs read 0 after
      // reset; a pure datapath flop behind a valid would not need it.
      m_data_q     <= '0;
      m_user_q     <= '0;
      pause_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_user_q     <= m_user_d;
      pause_ack_q  <= pause_ack_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign pause_ack     = pause_ack_q;

`ifdef ACC_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      stat_d[r] = stat_q[r];
      if (xfer && grant_q == ID_W'(r)) stat_d[r] = stat_q[r] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_beats = stat_q;
`else
  assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_acc_buf_arbiter.sv
// ---------------------------------------------------------------------------
// tb_acc_buf_arbiter
// Directed bench for acc_buf_arbiter (NREQ=4, DBITS=64, MAX_BURST=8).
// Cycle tables cover stalls, pause and burst truncation; monitored beat logs
// cover full-rate round-robin ordering. Beat data of requester r, k-th beat
// is {r[7:0], 24'h0, k[31:0]}.
// ---------------------------------------------------------------------------
module tb_acc_buf_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   s_tvalid = '0;
  logic [255:0] s_tdata;
  logic [3:0]   s_tready;
  logic         m_tvalid;
  logic [63:0]  m_tdata;
  logic [1:0]   m_tuser;
  logic         m_tready = 1'b1;
  logic         pause_req = 1'b0;
  logic         pause_ack;
  logic [127:0] stat_beats;

  always #5 clock = ~clock;

  acc_buf_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .pause_req     (pause_req),
    .pause_ack     (pause_ack),
    .stat_beats    (stat_beats)
  );

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] mk(input int r, input int k);
    logic [7:0] rr;
    rr = r[7:0];
    return {rr, 24'h0, k};
  endfunction

  // Source side: each requester presents its next beat; advanced on handshake.
  int         seq [4];
  int         cyc;
  int         oh_err;
  logic [3:0] hs_s;

  typedef struct {
    int          cyc;
    logic [1:0]  user;
    logic [63:0] data;
  } beat_t;
  beat_t mlog[$];

  always_comb begin
    for (int r = 0; r < 4; r++) s_tdata[r*64 +: 64] = mk(r, seq[r]);
  end

  always @(negedge clock) begin
    if (reset) begin
      hs_s = '0;
      oh_err = 0;
      mlog.delete();
    end else begin
      hs_s = s_tvalid & s_tready;
      if ($countones(s_tready) > 1) oh_err++;
      if (m_tvalid && m_tready) mlog.push_back('{cyc, m_tuser, m_tdata});
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      cyc <= 0;
      for (int r = 0; r < 4; r++) seq[r] <= 0;
    end else begin
      cyc <= cyc + 1;
      for (int r = 0; r < 4; r++) if (hs_s[r]) seq[r] <= seq[r] + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Leaves the bench just after a rising edge with reset released (cycle 0).
  task automatic do_reset();
    reset     = 1'b1;
    s_tvalid  = '0;
    pause_req = 1'b0;
    m_tready  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit          first;
    logic [3:0]  vld;
    logic        mrdy;
    logic        preq;
    logic [3:0]  esrdy;
    logic        emv;
    logic [1:0]  euser;
    logic [63:0] edata;
    logic        epk;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit first, input logic [3:0] vld, input logic mrdy, input logic preq,
                     input logic [3:0] esrdy, input logic emv, input logic [1:0] euser,
                     input logic [63:0] edata, input logic epk);
    tbl.push_back('{first, vld, mrdy, preq, esrdy, emv, euser, edata, epk});
  endtask

  initial begin
    logic [63:0] exp3;
    int b, k, src, idx;

    // ---- vectors: stall mid-burst, burst completion, pause with held beat
    add(1, 4'b0010, 1, 0, 4'b0000, 0, 0, 64'h0,     0); // IDLE, grant 1 next
    add(0, 4'b0010, 1, 0, 4'b0010, 0, 0, 64'h0,     0);
    add(0, 4'b0010, 1, 0, 4'b0010, 1, 1, mk(1, 0),  0);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 0, 0, 4'b0000, 1, 1, mk(1, 1), 0); // held beat, no s-side
    add(0, 4'b0010, 1, 0, 4'b0010, 1, 1, mk(1, 1),  0);
    for (int j = 2; j <= 6; j++)
      add(0, 4'b0010, 1, 0, 4'b0010, 1, 1, mk(1, j), 0);
    add(0, 4'b0010, 1, 0, 4'b0000, 1, 1, mk(1, 7),  0); // bubble after 8 beats
    add(0, 4'b0010, 1, 0, 4'b0010, 0, 0, 64'h0,     0); // same requester again
    add(0, 4'b0010, 0, 1, 4'b0000, 1, 1, mk(1, 8),  0); // pause while stalled
    add(0, 4'b0010, 0, 1, 4'b0000, 1, 1, mk(1, 8),  0);
    add(0, 4'b0010, 0, 1, 4'b0000, 1, 1, mk(1, 8),  0);
    add(0, 4'b0010, 1, 1, 4'b0000, 1, 1, mk(1, 8),  0); // held beat accepted
    add(0, 4'b0010, 1, 1, 4'b0000, 0, 0, 64'h0,     0);
    add(0, 4'b0010, 1, 1, 4'b0000, 0, 0, 64'h0,     1);
    add(0, 4'b0010, 1, 0, 4'b0000, 0, 0, 64'h0,     1); // release
    add(0, 4'b0110, 1, 0, 4'b0000, 0, 0, 64'h0,     0); // IDLE, next after 1
    add(0, 4'b0110, 1, 0, 4'b0100, 0, 0, 64'h0,     0);
    add(0, 4'b0110, 1, 0, 4'b0100, 1, 2, mk(2, 0),  0);
    // ---- vectors: requester 1 drops after 3 beats, requester 3 next
    add(1, 4'b1010, 1, 0, 4'b0000, 0, 0, 64'h0,     0);
    add(0, 4'b1010, 1, 0, 4'b0010, 0, 0, 64'h0,     0);
    add(0, 4'b1010, 1, 0, 4'b0010, 1, 1, mk(1, 0),  0);
    add(0, 4'b1010, 1, 0, 4'b0010, 1, 1, mk(1, 1),  0);
    add(0, 4'b1000, 1, 0, 4'b0010, 1, 1, mk(1, 2),  0);
    add(0, 4'b1000, 1, 0, 4'b0000, 0, 0, 64'h0,     0);
    add(0, 4'b1000, 1, 0, 4'b1000, 0, 0, 64'h0,     0);
    add(0, 4'b1000, 1, 0, 4'b1000, 1, 3, mk(3, 0),  0);

    // ---- reset state
    do_reset();
    @(negedge clock);
    check("rst srdy",  64'(s_tready),  64'h0);
    check("rst mvld",  64'(m_tvalid),  64'h0);
    check("rst tdata", m_tdata,        64'h0);
    check("rst tuser", 64'(m_tuser),   64'h0);
    check("rst pack",  64'(pause_ack), 64'h0);
    check("rst stats", stat_beats[63:0] | stat_beats[127:64], 64'h0);
    @(posedge clock); #1;

    // ---- table-driven cycles
    foreach (tbl[i]) begin
      if (tbl[i].first) do_reset();
      s_tvalid  = tbl[i].vld;
      m_tready  = tbl[i].mrdy;
      pause_req = tbl[i].preq;
      @(negedge clock);
      check($sformatf("v%0d srdy", i), 64'(s_tready),  64'(tbl[i].esrdy));
      check($sformatf("v%0d mvld", i), 64'(m_tvalid),  64'(tbl[i].emv));
      check($sformatf("v%0d pack", i), 64'(pause_ack), 64'(tbl[i].epk));
      if (tbl[i].emv) begin
        check($sformatf("v%0d user", i), 64'(m_tuser), 64'(tbl[i].euser));
        check($sformatf("v%0d data", i), m_tdata,      tbl[i].edata);
      end
      @(posedge clock); #1;
    end

    // ---- requesters 0 and 2 at full rate: 8 + bubble + 8 + bubble + 0 again
    do_reset();
    s_tvalid = 4'b0101;
    repeat (26) begin @(posedge clock); #1; end
    check("t1 beats", 64'(mlog.size() >= 20), 64'h1);
    for (int i = 0; i < 20; i++) begin
      if (i < mlog.size()) begin
        b = i / 8; k = i % 8;
        src = (b % 2 == 1) ? 2 : 0;
        idx = (b / 2) * 8 + k;
        check($sformatf("t1 b%0d cyc", i),  64'(mlog[i].cyc),  64'(2 + i + b));
        check($sformatf("t1 b%0d user", i), 64'(mlog[i].user), 64'(src));
        check($sformatf("t1 b%0d data", i), mlog[i].data,      mk(src, idx));
      end
    end

    // ---- reset mid-burst drops the slice beat
    do_reset();
    s_tvalid = 4'b0001;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    check("mid rst pre mvld", 64'(m_tvalid), 64'h1);
    @(posedge clock); #1;
    m_tready = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    check("mid rst mvld", 64'(m_tvalid), 64'h0);
    check("mid rst srdy", 64'(s_tready), 64'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // ---- all four requesters: order 0,1,2,3,0, bursts of 8, one-hot ready
    do_reset();
    s_tvalid = 4'b1111;
    repeat (48) begin @(posedge clock); #1; end
    check("t2 beats", 64'(mlog.size() >= 40), 64'h1);
    check("t2 onehot", 64'(oh_err), 64'h0);
    for (int i = 0; i < 40; i++) begin
      if (i < mlog.size()) begin
        b = i / 8; k = i % 8;
        src = b % 4;
        idx = (b / 4) * 8 + k;
        check($sformatf("t2 b%0d cyc", i),  64'(mlog[i].cyc),  64'(2 + i + b));
        check($sformatf("t2 b%0d user", i), 64'(mlog[i].user), 64'(src));
        check($sformatf("t2 b%0d data", i), mlog[i].data,      mk(src, idx));
      end
    end

    // ---- statistics: 20 beats from requester 3, then reset
    do_reset();
    repeat (40) begin
      s_tvalid = {seq[3] < 20, 3'b000};
      @(posedge clock); #1;
    end
    s_tvalid = '0;
`ifdef ACC_ARB_STATS_EN
    exp3 = 64'd20;
`else
    exp3 = 64'd0;
`endif
    @(negedge clock);
    check("t6 sent",  64'(seq[3]),           64'd20);
    check("t6 stat3", 64'(stat_beats[127:96]), exp3);
    check("t6 stat0", 64'(stat_beats[31:0]),   64'h0);
    check("t6 stat1", 64'(stat_beats[63:32]),  64'h0);
    check("t6 stat2", 64'(stat_beats[95:64]),  64'h0);
    @(posedge clock); #1;
    do_reset();
    @(negedge clock);
    check("t6 rst stats", stat_beats[63:0] | stat_beats[127:64], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
